// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter for a shared resource.
//   The winner keeps the grant as long as it holds its request. On release the
//   rotation pointer moves one past the released owner. There is always exactly
//   one IDLE cycle between two grants.
//   Optional feature macro: ARB_TIMEOUT_EN. When it is defined, an owner is
//   forced off after MAX_HOLD grant cycles and the arbiter emits a one-cycle
//   timeout pulse.

// Per-requester lane. It decides whether requester IDX wins given the pointer.
// Candidates are scanned in order ptr, ptr+1, ... (mod N). IDX wins when it
// requests and no requester before it in that scan order requests.
module rr_arb_lane #(
  parameter int N   = 4,
  parameter int IDX = 0
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 win
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] pos;
  logic          seen;
  logic          blocked;

  // Walk the rotation order until this lane is reached, collecting blockers.
  always_comb begin
    win     = 1'b0;
    seen    = 1'b0;
    blocked = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = ptr + PW'(k);
      if (!seen) begin
        if (pos == PW'(IDX)) begin
          seen = 1'b1;
          win  = req[IDX] & ~blocked;
        end else begin
          blocked = blocked | req[pos];
        end
      end
    end
  end
endmodule

module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state;
  logic [1:0]           ptr;
  logic [NUM_LANES-1:0] win;
  logic [1:0]           win_id;
  logic                 owner_req;

  // The legal range is 2..255, and the counter must be able to reach
  // MAX_HOLD. This block exists only to mark a bad configuration and builds
  // no hardware.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
  end

  // One lane per requester computes its own "I win" bit from the pointer.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_arb_lane #(.N(NUM_LANES), .IDX(g)) u_lane (
      .req (req),
      .ptr (ptr),
      .win (win[g])
    );
  end

  // Encode the one-hot winner into a binary index.
  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (win[i]) win_id = 2'(i);
  end

  assign owner_req = req[grant_id];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  // Arbitration FSM with a hold limit. All outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= win;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= CNT_W'(1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_id + 2'd1;
            state       <= IDLE;
          end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            // Forced release. The owner re-competes like everyone else.
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_id + 2'd1;
            timeout     <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Arbitration FSM without a hold limit. All outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= 2'd0;
      grant_valid <= 1'b0;
      ptr         <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= win;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_id + 2'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4. Tests the timeout scenario when
// ARB_TIMEOUT_EN is defined, and the unlimited hold otherwise.
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int tests = 0;
  int failed = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      failed++;
      $display("FAIL reset: grant=%b valid=%b id=%0d, need 0000/0/0", grant, grant_valid, grant_id);
    end
`ifdef ARB_TIMEOUT_EN
    tests++;
    if (timeout !== 1'b0) begin
      failed++;
      $display("FAIL reset_timeout: got %b need 0", timeout);
    end
`endif
    req   = 4'b0000;
    reset = 1'b0;
  endtask

  // Scenario 1: a request raised one cycle after reset is granted on the next edge.
  task automatic test_latency();
    tick();
    tests++;
    if (grant !== 4'b0000) begin
      failed++;
      $display("FAIL idle_no_req: grant=%b need 0000", grant);
    end
    req = 4'b0100;
    tick();
    tests++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      failed++;
      $display("FAIL latency: grant=%b id=%0d valid=%b need 0100/2/1", grant, grant_id, grant_valid);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd2) begin
      failed++;
      $display("FAIL release: grant=%b valid=%b id=%0d need 0000/0/2", grant, grant_valid, grant_id);
    end
  endtask

  // Scenario 2: all four request, each holds 3 cycles, order 0,1,2,3,0.
  task automatic test_all_req();
    logic [3:0] exp_g;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    foreach (order[n]) begin
      exp_g = 4'b0001 << order[n];
      for (int c = 0; c < 3; c++) begin
        tick();
        tests++;
        if (grant !== exp_g || grant_id !== 2'(order[n])) begin
          failed++;
          $display("FAIL rotate[%0d] c%0d: grant=%b id=%0d need %b/%0d", n, c, grant, grant_id, exp_g, order[n]);
        end
      end
      req[order[n]] = 1'b0;
      tick();
      tests++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        failed++;
        $display("FAIL rotate_idle[%0d]: grant=%b valid=%b need 0000/0", n, grant, grant_valid);
      end
      req[order[n]] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // Scenarios 3 and 4: no preemption, then the pointer wraps from 3 to 0.
  task automatic test_no_preempt_wrap();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (grant !== 4'b0010) begin
        failed++;
        $display("FAIL no_preempt c%0d: grant=%b need 0010", c, grant);
      end
    end
    req = 4'b1000;
    tick();
    tests++;
    if (grant !== 4'b0000) begin
      failed++;
      $display("FAIL preempt_release: grant=%b need 0000", grant);
    end
    tick();
    tests++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      failed++;
      $display("FAIL next_owner: grant=%b id=%0d need 1000/3", grant, grant_id);
    end
    // Owner 3 drops while 0 and 1 raise in the same cycle.
    req = 4'b0011;
    tick();
    tests++;
    if (grant !== 4'b0000) begin
      failed++;
      $display("FAIL wrap_idle: grant=%b need 0000", grant);
    end
    tick();
    tests++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failed++;
      $display("FAIL wrap: grant=%b id=%0d need 0001/0", grant, grant_id);
    end
    req = 4'b0000;
    tick();
  endtask

  // Scenario 5: an asynchronous reset mid-grant clears at once and rewinds the pointer.
  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0100) begin
      failed++;
      $display("FAIL pre_reset: grant=%b need 0100", grant);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      failed++;
      $display("FAIL async_reset: grant=%b valid=%b need 0000/0", grant, grant_valid);
    end
    tick();
    reset = 1'b0;
    req   = 4'b0110;
    tick();
    tests++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      failed++;
      $display("FAIL post_reset: grant=%b id=%0d need 0010/1", grant, grant_id);
    end
    req = 4'b0000;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  // Scenario 6: with two held requesters, each gets 8 cycles, then a timeout pulse and an idle cycle.
  task automatic test_timeout();
    logic [3:0] exp_g;
    int owners [3] = '{0, 1, 0};
    do_reset();
    req = 4'b0011;
    foreach (owners[n]) begin
      exp_g = 4'b0001 << owners[n];
      for (int c = 0; c < 8; c++) begin
        tick();
        tests++;
        if (grant !== exp_g || timeout !== 1'b0) begin
          failed++;
          $display("FAIL hold[%0d] c%0d: grant=%b to=%b need %b/0", n, c, grant, timeout, exp_g);
        end
      end
      tick();
      tests++;
      if (grant !== 4'b0000 || timeout !== 1'b1) begin
        failed++;
        $display("FAIL timeout[%0d]: grant=%b to=%b need 0000/1", n, grant, timeout);
      end
    end
    req = 4'b0000;
    tick();
    tests++;
    if (timeout !== 1'b0) begin
      failed++;
      $display("FAIL timeout_pulse: to=%b need 0", timeout);
    end
  endtask
`else
  // With no hold limit, the owner keeps the grant well past 8 cycles.
  task automatic test_long_hold();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
      tests++;
      if (grant !== 4'b0001) begin
        failed++;
        $display("FAIL long_hold c%0d: grant=%b need 0001", c, grant);
      end
    end
    req = 4'b0010;
    tick();
    tick();
    tests++;
    if (grant !== 4'b0010) begin
      failed++;
      $display("FAIL long_hold_next: grant=%b need 0010", grant);
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_all_req();
    test_no_preempt_wrap();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
